// File: rtl/status_unit.sv
// Processor status (P) register, branch evaluation and IRQ/NMI condition logic for the hmc-6502 core.
// Optional macro STATUS_DECIMAL_EN enables a writable D flag; without it the core is binary-only.
module status_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_overflow,
    input  logic       alu_c_out,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_in,
    input  logic       push_brk,
    output logic [7:0] p_out,
    output logic       c_flag,
    output logic       d_flag,
    output logic       i_flag,
    input  logic [2:0] br_sel,
    output logic       br_taken,
    input  logic       irq_b,
    input  logic       nmi_b,
    input  logic       nmi_ack,
    output logic       irq_pending,
    output logic       nmi_pending
);

    localparam logic [2:0] FOP_CLC = 3'd1;
    localparam logic [2:0] FOP_SEC = 3'd2;
    localparam logic [2:0] FOP_CLI = 3'd3;
    localparam logic [2:0] FOP_SEI = 3'd4;
    localparam logic [2:0] FOP_CLD = 3'd5;
    localparam logic [2:0] FOP_SED = 3'd6;
    localparam logic [2:0] FOP_CLV = 3'd7;

    logic r_n, r_v, r_d, r_i, r_z, r_c;
    logic r_i_dly;
    logic r_irq_s1, r_irq_s2;
    logic r_nmi_s1, r_nmi_s2, r_nmi_s3;
    logic r_nmi_pending;

    logic w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;
    logic w_nmi_fall;
    logic w_unused_bits;

`ifdef STATUS_DECIMAL_EN
    assign w_unused_bits = ^{p_in[5:4]};
`else
    assign w_unused_bits = ^{p_in[5:3]};
`endif

    // Next-state flags: p_load dominates, otherwise ALU enables with flag_op taking the last word
    always_comb begin
        w_n_nxt = r_n;
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        w_i_nxt = r_i;
        w_z_nxt = r_z;
        w_c_nxt = r_c;
        if (p_load) begin
            w_n_nxt = p_in[7];
            w_v_nxt = p_in[6];
            w_d_nxt = p_in[3];
            w_i_nxt = p_in[2];
            w_z_nxt = p_in[1];
            w_c_nxt = p_in[0];
        end else begin
            if (upd_nz) begin
                w_n_nxt = alu_negative;
                w_z_nxt = alu_zero;
            end else begin
                w_n_nxt = r_n;
                w_z_nxt = r_z;
            end
            if (upd_c) begin
                w_c_nxt = alu_c_out;
            end else begin
                w_c_nxt = r_c;
            end
            if (upd_v) begin
                w_v_nxt = alu_overflow;
            end else begin
                w_v_nxt = r_v;
            end
            case (flag_op)
                FOP_CLC: w_c_nxt = 1'b0;
                FOP_SEC: w_c_nxt = 1'b1;
                FOP_CLI: w_i_nxt = 1'b0;
                FOP_SEI: w_i_nxt = 1'b1;
                FOP_CLD: w_d_nxt = 1'b0;
                FOP_SED: w_d_nxt = 1'b1;
                FOP_CLV: w_v_nxt = 1'b0;
                default: w_d_nxt = w_d_nxt;
            endcase
        end
`ifndef STATUS_DECIMAL_EN
        w_d_nxt = 1'b0;
`endif
    end

    // Stored flag register plus the one-cycle-late copy of I used for IRQ masking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_d     <= 1'b0;
            r_i     <= 1'b1;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_i_dly <= 1'b1;
        end else begin
            r_n     <= w_n_nxt;
            r_v     <= w_v_nxt;
            r_d     <= w_d_nxt;
            r_i     <= w_i_nxt;
            r_z     <= w_z_nxt;
            r_c     <= w_c_nxt;
            r_i_dly <= r_i;
        end
    end

    // Two-flop synchronisers; r_nmi_s3 keeps the previous synchronised NMI level for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_s1 <= 1'b1;
            r_irq_s2 <= 1'b1;
            r_nmi_s1 <= 1'b1;
            r_nmi_s2 <= 1'b1;
            r_nmi_s3 <= 1'b1;
        end else begin
            r_irq_s1 <= irq_b;
            r_irq_s2 <= r_irq_s1;
            r_nmi_s1 <= nmi_b;
            r_nmi_s2 <= r_nmi_s1;
            r_nmi_s3 <= r_nmi_s2;
        end
    end

    assign w_nmi_fall = r_nmi_s3 & ~r_nmi_s2;

    // A fresh falling edge outranks an acknowledge arriving in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nmi_pending <= 1'b0;
        end else if (w_nmi_fall) begin
            r_nmi_pending <= 1'b1;
        end else if (nmi_ack) begin
            r_nmi_pending <= 1'b0;
        end else begin
            r_nmi_pending <= r_nmi_pending;
        end
    end

    // Branch condition: br_sel[2:1] picks the flag, br_sel[0] the polarity that takes the branch
    always_comb begin
        br_taken = 1'b0;
        case (br_sel)
            3'd0:    br_taken = ~r_n;
            3'd1:    br_taken = r_n;
            3'd2:    br_taken = ~r_v;
            3'd3:    br_taken = r_v;
            3'd4:    br_taken = ~r_c;
            3'd5:    br_taken = r_c;
            3'd6:    br_taken = ~r_z;
            3'd7:    br_taken = r_z;
            default: br_taken = 1'b0;
        endcase
    end

    assign p_out       = {r_n, r_v, 1'b1, push_brk, r_d, r_i, r_z, r_c};
    assign c_flag      = r_c;
    assign d_flag      = r_d;
    assign i_flag      = r_i;
    assign irq_pending = ~r_irq_s2 & ~r_i_dly;
    assign nmi_pending = r_nmi_pending;

endmodule
